load_store_unit: RTL and testbench

Initiator side of the hart's data-memory port. Accepts one load or store per handshake from the execute/memory stage and converts RISC-V byte addresses and sizes (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on the synchronous-read, word-addressed data memory. The memory has no byte enables, so sub-word stores are done as read-modify-write. Misaligned and out-of-range accesses are reported as errors and never reach memory.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_if.sv | 29 ++
 rtl/lsu_align.sv | 41 ++++
 rtl/load_store_unit.sv | 95 +++++++++
 tb/tb_load_store_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and state encoding for the load/store unit.
package lsu_pkg;
    localparam int MEM_WORDS_DEF = 1024;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;
endpackage

// File: rtl/lsu_if.sv
// Request/response and data-memory signals of the load/store unit.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_we, mem_re, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_we, mem_re, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte/half lane selection: extends load data and merges sub-word store data
// into the word read back from memory.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] sdata
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b     = rdata[{off, 3'b000} +: 8];
        h     = off[1] ? rdata[31:16] : rdata[15:0];
        ldata = rdata;
        sdata = wdata;
        case (funct3)
            F3_B:    ldata = {{24{b[7]}}, b};
            F3_H:    ldata = {{16{h[15]}}, h};
            F3_BU:   ldata = {24'b0, b};
            F3_HU:   ldata = {16'b0, h};
            default: ldata = rdata;
        endcase
        // Only the addressed lane changes; other bytes come from the read-back word.
        case (funct3[1:0])
            2'b00: begin
                sdata = rdata;
                sdata[{off, 3'b000} +: 8] = wdata[7:0];
            end
            2'b01: begin
                sdata = rdata;
                sdata[{off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: sdata = wdata;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns byte-addressed RV32I loads/stores into word
// accesses, with read-modify-write for SB/SH and early error responses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.master bus
);
    state_t      state, state_nxt;
    logic        legal_f3, misalign, oor, req_err, accept;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        we_q;
    logic [31:0] mem_addr_q, mem_wdata_q, rdata_q;
    logic        err_q;
    logic [31:0] ldata, sdata;

    always_comb begin
        legal_f3 = bus.req_we ? (bus.req_funct3 inside {F3_B, F3_H, F3_W})
                              : (bus.req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misalign = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
        oor      = {2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS);
        req_err  = !legal_f3 || misalign || oor;
        accept   = (state == IDLE) && bus.req_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.req_valid)
                      state_nxt = req_err ? RESP :
                                  (bus.req_we && bus.req_funct3 == F3_W) ? WR : RD;
            RD:      state_nxt = CAP;
            CAP:     state_nxt = we_q ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gating with rst_n keeps a reset landing in the WR cycle from committing the write.
    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == RESP);
        bus.mem_re     = (state == RD);
        bus.mem_we     = (state == WR) && rst_n;
    end

    // mem_wdata holds the store data until CAP replaces it with the merged word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f3_q        <= '0;
            off_q       <= '0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else if (accept) begin
            f3_q        <= bus.req_funct3;
            off_q       <= bus.req_addr[1:0];
            we_q        <= bus.req_we;
            mem_addr_q  <= {2'b00, bus.req_addr[31:2]};
            mem_wdata_q <= bus.req_wdata;
            rdata_q     <= '0;
            err_q       <= req_err;
        end else if (state == CAP) begin
            if (we_q) mem_wdata_q <= sdata;
            else      rdata_q     <= ldata;
        end
    end

    lsu_align u_align (
        .funct3 (f3_q),
        .off    (off_q),
        .rdata  (bus.mem_rdata),
        .wdata  (mem_wdata_q),
        .ldata  (ldata),
        .sdata  (sdata)
    );

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-in-WR sequence and
// randomized accesses against a byte-arithmetic reference model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int MW = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if bus();

    load_store_unit #(.MEM_WORDS(MW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem    [0:MW-1];
    logic [31:0] refmem [0:MW-1];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[9:0]];
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_re;
        int          exp_we;
        logic [31:0] exp_word;
    } vec_t;

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] init, logic [31:0] exp_rd, logic exp_err,
                                int exp_lat, int exp_re, int exp_we, logic [31:0] exp_word);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.init = init;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_re = exp_re; v.exp_we = exp_we; v.exp_word = exp_word;
        return v;
    endfunction

    // One transaction; cycles are counted from the accept edge (cycle 0 = accept).
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                          output logic er, output int re_c, output int we_c,
                          output logic [31:0] wd, output logic both);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = -1; re_c = -1; we_c = -1; rd = 'x; er = 1'bx; wd = 'x; both = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.mem_re && re_c < 0) re_c = c;
            if (bus.mem_we && we_c < 0) begin we_c = c; wd = bus.mem_wdata; end
            if (bus.mem_re && bus.mem_we) both = 1'b1;
            if (bus.resp_valid) begin lat = c; rd = bus.resp_rdata; er = bus.resp_err; break; end
        end
    endtask

    // Reference: works on whole bytes with shifts and modular arithmetic.
    function automatic void ref_acc(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] wd, output logic [31:0] rd, output logic er,
                                    output int lat, output int re_c, output int we_c);
        longint idx = longint'(a) / 4;
        int     off = int'(a % 4);
        int     sz  = 1 << f3[1:0];
        bit     legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        longint word, val, lane, mask;
        rd = 32'h0; re_c = -1; we_c = -1;
        er = !legal || (off % sz != 0) || idx >= MW;
        if (er) begin lat = 1; return; end
        word = longint'(refmem[idx]);
        lane = 64'd1 << (8 * sz);
        if (!we) begin
            lat = 3; re_c = 1;
            val = (word >> (8 * off)) % lane;
            if (!f3[2] && sz < 4 && val >= lane / 2) val = val - lane;
            rd = 32'(val);
        end else begin
            mask = (lane - 1) << (8 * off);
            refmem[idx] = 32'((word & ~mask) | ((longint'(wd) << (8 * off)) & mask));
            lat  = (sz == 4) ? 2 : 4;
            we_c = (sz == 4) ? 1 : 3;
            re_c = (sz == 4) ? -1 : 1;
        end
    endfunction

    initial begin
        vec_t tbl[$];
        int lat, re_c, we_c, idx;
        logic [31:0] rd, wd;
        logic er, both;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.mem_rdata = '0;
        for (int i = 0; i < MW; i++) mem[i] = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_re", 32'(bus.mem_re), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        rst_n = 1'b1;

        //                   we  f3     addr          wdata         init          exp_rd       err lat re we  exp_word
        tbl.push_back(mk(0, F3_W,  32'h10,   32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 3, 1, -1, 32'hDEADBEEF));
        tbl.push_back(mk(0, F3_B,  32'h13,   32'h0,        32'h80FF7F01, 32'hFFFFFF80, 0, 3, 1, -1, 32'h80FF7F01));
        tbl.push_back(mk(0, F3_BU, 32'h13,   32'h0,        32'h80FF7F01, 32'h00000080, 0, 3, 1, -1, 32'h80FF7F01));
        tbl.push_back(mk(0, F3_H,  32'h12,   32'h0,        32'h80FF7F01, 32'hFFFF80FF, 0, 3, 1, -1, 32'h80FF7F01));
        tbl.push_back(mk(0, F3_HU, 32'h12,   32'h0,        32'h80FF7F01, 32'h000080FF, 0, 3, 1, -1, 32'h80FF7F01));
        tbl.push_back(mk(0, F3_B,  32'h10,   32'h0,        32'h80FF7F01, 32'h00000001, 0, 3, 1, -1, 32'h80FF7F01));
        tbl.push_back(mk(0, F3_H,  32'h10,   32'h0,        32'h80FF7F01, 32'h00007F01, 0, 3, 1, -1, 32'h80FF7F01));
        tbl.push_back(mk(1, F3_B,  32'h11,   32'h000000AA, 32'h11223344, 32'h0,        0, 4, 1, 3,  32'h1122AA44));
        tbl.push_back(mk(1, F3_H,  32'h12,   32'h0000BEEF, 32'h11223344, 32'h0,        0, 4, 1, 3,  32'hBEEF3344));
        tbl.push_back(mk(1, F3_W,  32'h20,   32'hCAFEF00D, 32'h00000000, 32'h0,        0, 2, -1, 1, 32'hCAFEF00D));
        tbl.push_back(mk(0, F3_W,  32'h20,   32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 0, 3, 1, -1, 32'hCAFEF00D));
        tbl.push_back(mk(0, F3_W,  32'h02,   32'h0,        32'h55AA55AA, 32'h0,        1, 1, -1, -1, 32'h55AA55AA));
        tbl.push_back(mk(0, F3_H,  32'h01,   32'h0,        32'h55AA55AA, 32'h0,        1, 1, -1, -1, 32'h55AA55AA));
        tbl.push_back(mk(0, 3'b011, 32'h10,  32'h0,        32'h55AA55AA, 32'h0,        1, 1, -1, -1, 32'h55AA55AA));
        tbl.push_back(mk(0, F3_W,  32'h1000, 32'h0,        32'h0,        32'h0,        1, 1, -1, -1, 32'h0));
        tbl.push_back(mk(1, F3_BU, 32'h10,   32'h12345678, 32'h55AA55AA, 32'h0,        1, 1, -1, -1, 32'h55AA55AA));
        tbl.push_back(mk(1, F3_W,  32'h13,   32'h12345678, 32'h55AA55AA, 32'h0,        1, 1, -1, -1, 32'h55AA55AA));

        foreach (tbl[i]) begin
            idx = int'(tbl[i].addr >> 2);
            @(negedge clk);
            if (idx < MW) mem[idx] = tbl[i].init;
            do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, lat, rd, er, re_c, we_c, wd, both);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
            chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
            chk($sformatf("v%0d_re_cycle", i), 32'(re_c), 32'(tbl[i].exp_re));
            chk($sformatf("v%0d_we_cycle", i), 32'(we_c), 32'(tbl[i].exp_we));
            chk($sformatf("v%0d_re_we_overlap", i), 32'(both), 32'h0);
            if (tbl[i].exp_we >= 0) chk($sformatf("v%0d_mem_wdata", i), wd, tbl[i].exp_word);
            if (tbl[i].exp_we == 1) chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, tbl[i].addr >> 2);
            if (idx < MW) chk($sformatf("v%0d_mem_after", i), mem[idx], tbl[i].exp_word);
        end

        // Reset asserted during the WR cycle of an SB must not write memory.
        @(negedge clk);
        mem[4] = 32'h11223344;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_B;
        bus.req_addr = 32'h11; bus.req_wdata = 32'hAA;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b0;
        #1 chk("rstwr_mem_we", 32'(bus.mem_we), 32'h0);
        @(negedge clk);
        chk("rstwr_mem_we_neg", 32'(bus.mem_we), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        chk("rstwr_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rstwr_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rstwr_mem_addr", bus.mem_addr, 32'h0);
        chk("rstwr_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rstwr_mem_unchanged", mem[4], 32'h11223344);
        @(negedge clk);
        chk("rstwr_no_resp", 32'(bus.resp_valid), 32'h0);
        do_req(1'b0, F3_W, 32'h10, 32'h0, lat, rd, er, re_c, we_c, wd, both);
        chk("rstwr_lw_lat", 32'(lat), 32'd3);
        chk("rstwr_lw_rdata", rd, 32'h11223344);
        chk("rstwr_lw_err", 32'(er), 32'h0);

        // Randomized accesses over a small window plus occasional far addresses.
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            refmem[i] = mem[i];
        end
        for (int n = 0; n < 300; n++) begin
            logic        r_we;
            logic [2:0]  r_f3;
            logic [31:0] r_addr, r_wd, e_rd;
            logic        e_er;
            int          e_lat, e_re, e_we;
            r_we = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            r_wd = $urandom;
            case ($urandom_range(0, 19))
                0:       r_addr = (32'(MW) << 2) + 32'($urandom_range(0, 15));
                1:       r_addr = $urandom;
                default: r_addr = 32'($urandom_range(0, 63));
            endcase
            ref_acc(r_we, r_f3, r_addr, r_wd, e_rd, e_er, e_lat, e_re, e_we);
            do_req(r_we, r_f3, r_addr, r_wd, lat, rd, er, re_c, we_c, wd, both);
            chk($sformatf("r%0d_lat", n), 32'(lat), 32'(e_lat));
            chk($sformatf("r%0d_rdata", n), rd, e_rd);
            chk($sformatf("r%0d_err", n), 32'(er), 32'(e_er));
            chk($sformatf("r%0d_re_cycle", n), 32'(re_c), 32'(e_re));
            chk($sformatf("r%0d_we_cycle", n), 32'(we_c), 32'(e_we));
            if (!e_er && r_addr < 32'h40)
                chk($sformatf("r%0d_mem", n), mem[r_addr >> 2], refmem[r_addr >> 2]);
        end
        for (int i = 0; i < 16; i++) chk($sformatf("final_mem%0d", i), mem[i], refmem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
